// File: rtl/cpu_pc_unit_pkg.sv
// Shared definitions for the program-flow stage: jump-source encodings,
// default widths and a small decode helper.
package cpu_pc_unit_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 8;
  localparam int DEFAULT_STACK_DEPTH = 4;
  localparam int DEFAULT_STACK_PTR_W = 3;

  // Jump source select as driven by the decoder.
  typedef enum logic [1:0] {
    JMP_ABS = 2'b00,  // target = JMP_ADDR
    JMP_OFS = 2'b01,  // target = base + BASE_REG_OFFSET
    JMP_RET = 2'b10,  // target = link stack top, pop
    JMP_RSV = 2'b11   // reserved, behaves as ABS
  } jmp_mode_e;

  // True when the mode selects a return (pop) rather than a direct jump.
  function automatic logic is_ret(input logic [1:0] mode);
    return mode == JMP_RET;
  endfunction

endpackage

// File: rtl/cpu_pc_unit_if.sv
// Decoder-to-PC-unit bundle. The decoder (master) drives the flow-control
// fields, and the PC unit (slave) returns the program counter, base register
// and link-stack status.
//
// Transfer semantics: there is no valid/ready pair. Every field is sampled on
// each rising CLK edge while EN=1. EN=0 means nothing is consumed and all
// outputs hold. The slave never back-pressures.
interface cpu_pc_unit_if
  import cpu_pc_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int STACK_PTR_W = DEFAULT_STACK_PTR_W
);

  logic                   EN;
  logic                   PC_RST;
  logic                   PC_LD;
  logic [1:0]             JMP_MODE;
  logic [ADDR_WIDTH-1:0]  JMP_ADDR;
  logic [ADDR_WIDTH-1:0]  BASE_REG_OFFSET;
  logic                   BASE_REG_LD;
  logic [ADDR_WIDTH-1:0]  BASE_REG_DATA;
  logic                   LR_LD;

  logic [ADDR_WIDTH-1:0]  PC_OUT;
  logic [ADDR_WIDTH-1:0]  BASE_REG_OUT;
  logic [ADDR_WIDTH-1:0]  LR_OUT;
  logic [STACK_PTR_W-1:0] STACK_LVL;
  logic                   STACK_OVF;
  logic                   STACK_UNF;

  modport master (
    output EN, PC_RST, PC_LD, JMP_MODE, JMP_ADDR, BASE_REG_OFFSET,
           BASE_REG_LD, BASE_REG_DATA, LR_LD,
    input  PC_OUT, BASE_REG_OUT, LR_OUT, STACK_LVL, STACK_OVF, STACK_UNF
  );

  modport slave (
    input  EN, PC_RST, PC_LD, JMP_MODE, JMP_ADDR, BASE_REG_OFFSET,
           BASE_REG_LD, BASE_REG_DATA, LR_LD,
    output PC_OUT, BASE_REG_OUT, LR_OUT, STACK_LVL, STACK_OVF, STACK_UNF
  );

endinterface

// File: rtl/cpu_pc_unit_link_stack.sv
// Register-array LIFO holding CALL return addresses. A push into a full stack
// and a pop from an empty stack are dropped and latch sticky flags. The
// caller guarantees that push and pop are never asserted together.
module cpu_link_stack
  import cpu_pc_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH = DEFAULT_STACK_DEPTH,
  parameter int PTR_W = DEFAULT_STACK_PTR_W
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W-1:0] lvl,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] lvl_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // The level doubles as the write slot. The top entry sits one slot below it.
  assign wr_idx = lvl_q[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);
  assign full   = (lvl_q == PTR_W'(DEPTH));
  assign empty  = (lvl_q == '0);
  assign lvl    = lvl_q;
  assign top    = empty ? '0 : mem[rd_idx];

  // Level counter and sticky error flags. A clear discards everything at once.
  always_ff @(posedge CLK) begin
    if (clr) begin
      lvl_q <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (push) begin
        if (full) ovf   <= 1'b1;
        else      lvl_q <= lvl_q + PTR_W'(1);
      end
      if (pop) begin
        if (empty) unf   <= 1'b1;
        else       lvl_q <= lvl_q - PTR_W'(1);
      end
    end
  end

  // Entry storage. Contents are don't-care after a clear, so there is no reset.
  always_ff @(posedge CLK) begin
    if (!clr && push && !full) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/cpu_pc_unit.sv
// Program-flow stage. It holds the PC and the base register, selects the next
// PC by priority (PC_RST > PC_LD > increment), and drives a link stack for
// CALL/RET.
module cpu_pc_unit
  import cpu_pc_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH,
  parameter int STACK_PTR_W = DEFAULT_STACK_PTR_W
) (
  input logic         CLK,
  input logic         RST,
  cpu_pc_unit_if.slave bus
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  ret_jmp;
  logic                  stack_clr;
  logic                  stack_push;
  logic                  stack_pop;

  assign pc_inc  = pc_q + ADDR_WIDTH'(1);
  assign ret_jmp = bus.PC_LD & is_ret(bus.JMP_MODE);

  // A RET beats a simultaneous LR_LD, and PC_RST beats both.
  assign stack_clr  = RST | (bus.EN & bus.PC_RST);
  assign stack_push = bus.EN & ~bus.PC_RST & bus.LR_LD & ~ret_jmp;
  assign stack_pop  = bus.EN & ~bus.PC_RST & ret_jmp;

  // Next-PC priority mux. The OFS target uses the base value from before any
  // same-cycle load. A RET on an empty stack falls through to an increment.
  always_comb begin
    pc_d = pc_inc;
    if (bus.PC_RST) begin
      pc_d = '0;
    end else if (bus.PC_LD) begin
      case (jmp_mode_e'(bus.JMP_MODE))
        JMP_OFS: pc_d = base_q + bus.BASE_REG_OFFSET;
        JMP_RET: pc_d = stack_empty ? pc_inc : stack_top;
        default: pc_d = bus.JMP_ADDR;
      endcase
    end
  end

  // PC and base registers. EN=0 freezes both, but RST always acts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q   <= '0;
      base_q <= '0;
    end else if (bus.EN) begin
      pc_q <= pc_d;
      if (bus.BASE_REG_LD) base_q <= bus.BASE_REG_DATA;
    end
  end

  cpu_link_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH),
    .PTR_W (STACK_PTR_W)
  ) u_link_stack (
    .CLK       (CLK),
    .clr       (stack_clr),
    .push      (stack_push),
    .pop       (stack_pop),
    .push_data (pc_inc),
    .top       (stack_top),
    .lvl       (bus.STACK_LVL),
    .full      (stack_full),
    .empty     (stack_empty),
    .ovf       (bus.STACK_OVF),
    .unf       (bus.STACK_UNF)
  );

  assign bus.PC_OUT       = pc_q;
  assign bus.BASE_REG_OUT = base_q;
  assign bus.LR_OUT       = stack_top;

endmodule
